tb_multiport_mem: RTL and testbench

- Parametrised successor of the testbench dual-port byte-enable RAM used to back the RV32I pipeline's instruction and data ports.
- Generalises port count, width, depth and base address.
- Adds a per-port valid/ready request handshake with a programmable response latency and response backpressure, so stall and hazard logic can be exercised against slow memory.
- Deterministic byte-lane resolution when ports write the same word in the same cycle.

---
 rtl/tb_multiport_mem.sv | 101 ++++++++++
 tb/tb_tb_multiport_mem.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tb_multiport_mem.sv
// tb_multiport_mem: multi-port byte-enable RAM with a per-port valid/ready handshake,
// programmable response latency and response backpressure, plus zero-time back-door access.
module tb_multiport_mem #(
    parameter int          NUM_PORTS   = 2,
    parameter int          ADDR_W      = 14,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1,
    parameter bit          WRITE_FIRST = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    output logic [NUM_PORTS-1:0]          req_ready_o,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_be_i,
    output logic [NUM_PORTS-1:0]          rsp_valid_o,
    input  logic [NUM_PORTS-1:0]          rsp_ready_i,
    output logic [NUM_PORTS*DATA_W-1:0]   rsp_data_o
);
    localparam int BE_W = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] OFFSET = ADDR_W'(BASE_ADDR / BE_W);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    state_t            state_q [NUM_PORTS];
    state_t            state_d [NUM_PORTS];
    logic [3:0]        cnt_q   [NUM_PORTS];
    logic [3:0]        cnt_d   [NUM_PORTS];
    logic [DATA_W-1:0] data_q  [NUM_PORTS];
    logic [DATA_W-1:0] data_d  [NUM_PORTS];
    logic [DATA_W-1:0] rdata   [NUM_PORTS];
    logic [ADDR_W-1:0] idx     [NUM_PORTS];
    logic [NUM_PORTS-1:0] accept;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            idx[p] = req_addr_i[p*ADDR_W +: ADDR_W] + OFFSET;
            req_ready_o[p] = rst_i && state_q[p] == IDLE;
            accept[p] = req_valid_i[p] && req_ready_o[p];
            rsp_valid_o[p] = state_q[p] == RESP;
            rsp_data_o[p*DATA_W +: DATA_W] = rsp_valid_o[p] ? data_q[p] : '0;
            state_d[p] = state_q[p];
            cnt_d[p] = cnt_q[p];
            data_d[p] = data_q[p];
            // Reads sample the pre-edge array; write-first only merges this port's own bytes
            rdata[p] = mem_q[idx[p]];
            for (int b = 0; b < BE_W; b++)
                if (WRITE_FIRST && req_be_i[p*BE_W+b])
                    rdata[p][b*8 +: 8] = req_wdata_i[p*DATA_W + b*8 +: 8];
            case (state_q[p])
                IDLE: if (accept[p]) begin
                    data_d[p] = rdata[p];
                    cnt_d[p] = 4'(LATENCY - 1);
                    state_d[p] = LATENCY == 1 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_d[p] = cnt_q[p] - 4'd1;
                    state_d[p] = cnt_q[p] <= 4'd1 ? RESP : WAIT;
                end
                RESP: state_d[p] = rsp_ready_i[p] ? IDLE : RESP;
                default: state_d[p] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= IDLE;
                cnt_q[p] <= '0;
                data_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p] <= cnt_d[p];
                data_q[p] <= data_d[p];
            end
        end
    end

    // Highest port first so the lowest-numbered port's lane write lands last and wins
    always @(posedge clk_i) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--)
            for (int b = 0; b < BE_W; b++)
                if (accept[p] && req_be_i[p*BE_W+b])
                    mem_q[idx[p]][b*8 +: 8] <= req_wdata_i[p*DATA_W + b*8 +: 8];
    end

    task automatic write_byte(input logic [31:0] byte_addr, input logic [7:0] data);
        mem_q[ADDR_W'(byte_addr / BE_W)][(byte_addr % BE_W) * 8 +: 8] <= data;
    endtask

    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] word_index);
        return mem_q[word_index];
    endfunction
endmodule

// File: tb/tb_tb_multiport_mem.sv
// tb_tb_multiport_mem: scoreboard bench over five differently parametrised memory instances.
module tb_tb_multiport_mem;
    localparam int ND = 5;
    localparam int          LAT [ND] = '{1, 3, 1, 1, 4};
    localparam bit          WF  [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [31:0] BA  [ND] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h0};

    logic clk, rst_n;
    logic [1:0]  rv [ND], rr [ND], sv [ND], sr [ND];
    logic [27:0] ra [ND];
    logic [63:0] wd [ND], rd [ND];
    logic [7:0]  be [ND];
    logic [31:0] sb [ND*2][$];
    int tests = 0, failed = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        tb_multiport_mem #(
            .LATENCY(LAT[g]), .WRITE_FIRST(WF[g]), .BASE_ADDR(BA[g])
        ) u (
            .clk_i(clk), .rst_i(rst_n),
            .req_valid_i(rv[g]), .req_ready_o(rr[g]), .req_addr_i(ra[g]),
            .req_wdata_i(wd[g]), .req_be_i(be[g]),
            .rsp_valid_o(sv[g]), .rsp_ready_i(sr[g]), .rsp_data_o(rd[g])
        );
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic bd_write(input int d, input logic [31:0] ba_i, input logic [7:0] v);
        case (d)
            0: g_dut[0].u.write_byte(ba_i, v);
            1: g_dut[1].u.write_byte(ba_i, v);
            2: g_dut[2].u.write_byte(ba_i, v);
            3: g_dut[3].u.write_byte(ba_i, v);
            default: g_dut[4].u.write_byte(ba_i, v);
        endcase
    endtask

    function automatic logic [31:0] bd_read(input int d, input logic [13:0] i);
        case (d)
            0: return g_dut[0].u.read_word(i);
            1: return g_dut[1].u.read_word(i);
            2: return g_dut[2].u.read_word(i);
            3: return g_dut[3].u.read_word(i);
            default: return g_dut[4].u.read_word(i);
        endcase
    endfunction

    task automatic preload(input int d, input logic [13:0] w, input logic [31:0] v);
        for (int b = 0; b < 4; b++) bd_write(d, {16'b0, w, 2'b00} + 32'(b), v[b*8 +: 8]);
    endtask

    // Drive one request, wait (bounded) for ready, return #1 after the accepting edge
    task automatic issue(input int d, input int p, input logic [13:0] a, input logic [31:0] w,
                         input logic [3:0] b, input logic [31:0] exp);
        int n = 0;
        ra[d][p*14 +: 14] = a;
        wd[d][p*32 +: 32] = w;
        be[d][p*4 +: 4] = b;
        rv[d][p] = 1'b1;
        sb[d*2+p].push_back(exp);
        while (!rr[d][p] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) begin
            tests++;
            failed++;
            $display("FAIL ready timeout d%0d p%0d: got ready=0, required ready=1", d, p);
        end
        @(posedge clk); #1;
        rv[d][p] = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < 2; p++)
                if (sv[d][p]) begin
                    if (sb[d*2+p].size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL unexpected rsp d%0d p%0d: got data %h, required no response",
                                 d, p, rd[d][p*32 +: 32]);
                    end else begin
                        check($sformatf("rsp data d%0d p%0d", d, p), rd[d][p*32 +: 32], sb[d*2+p][0]);
                        if (sr[d][p]) void'(sb[d*2+p].pop_front());
                    end
                end
    end

    initial begin
        rst_n = 0;
        for (int d = 0; d < ND; d++) begin
            rv[d] = '0; sr[d] = '1; ra[d] = '0; wd[d] = '0; be[d] = '0;
        end
        @(negedge clk);
        check("reset ready", 32'(rr[0]), 32'h0);
        check("reset valid", 32'(sv[0]), 32'h0);
        check("reset data", rd[0][31:0], 32'h0);
        preload(0, 14'd5, 32'h0);
        preload(0, 14'd9, 32'h0);
        preload(0, 14'd2, 32'h12345678);
        preload(2, 14'd2, 32'h12345678);
        preload(1, 14'd7, 32'h11223344);
        preload(3, 14'h3F, 32'h0);
        preload(3, 14'h0, 32'h55667788);
        preload(4, 14'h20, 32'h0);
        @(negedge clk);
        rst_n = 1;
        #1 check("ready after release", 32'(rr[0]), 32'h3);
        @(posedge clk); #1;

        issue(0, 0, 14'd5, 32'hDEADBEEF, 4'hF, 32'h0);
        check("l1 write rsp valid", 32'(sv[0][0]), 32'h1);
        check("l1 ready low in rsp", 32'(rr[0][0]), 32'h0);
        @(posedge clk); #1;
        check("l1 ready back", 32'(rr[0][0]), 32'h1);
        check("l1 valid drops", 32'(sv[0][0]), 32'h0);
        issue(0, 0, 14'd5, 32'h0, 4'h0, 32'hDEADBEEF);
        check("l1 read rsp valid", 32'(sv[0][0]), 32'h1);
        check("backdoor word 5", bd_read(0, 14'd5), 32'hDEADBEEF);
        @(posedge clk); #1;

        check("both ports idle", 32'(rr[0]), 32'h3);
        ra[0] = {14'd9, 14'd9};
        wd[0] = {32'hBBBBBBBB, 32'hAAAAAAAA};
        be[0] = {4'b0110, 4'b0011};
        rv[0] = 2'b11;
        sb[0].push_back(32'h0);
        sb[1].push_back(32'h0);
        @(posedge clk); #1;
        rv[0] = 2'b00;
        check("lane merge word 9", bd_read(0, 14'd9), 32'h00BBAAAA);
        @(posedge clk); #1;

        issue(0, 0, 14'd2, 32'h000000FF, 4'h1, 32'h12345678);
        issue(2, 0, 14'd2, 32'h000000FF, 4'h1, 32'h123456FF);
        @(posedge clk); #1;
        check("read-first array", bd_read(0, 14'd2), 32'h123456FF);
        check("write-first array", bd_read(2, 14'd2), 32'h123456FF);

        sr[1][1] = 1'b0;
        issue(1, 1, 14'd7, 32'h0, 4'h0, 32'h11223344);
        check("l3 wait1 valid", 32'(sv[1][1]), 32'h0);
        check("l3 wait1 ready", 32'(rr[1][1]), 32'h0);
        @(posedge clk); #1;
        check("l3 wait2 valid", 32'(sv[1][1]), 32'h0);
        @(posedge clk); #1;
        check("l3 rsp valid", 32'(sv[1][1]), 32'h1);
        check("l3 rsp ready", 32'(rr[1][1]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("l3 stall valid %0d", i), 32'(sv[1][1]), 32'h1);
            check($sformatf("l3 stall ready %0d", i), 32'(rr[1][1]), 32'h0);
        end
        sr[1][1] = 1'b1;
        @(posedge clk); #1;
        check("l3 ready after accept", 32'(rr[1][1]), 32'h1);
        check("l3 valid after accept", 32'(sv[1][1]), 32'h0);

        issue(3, 0, 14'h3FFF, 32'hCAFEF00D, 4'hF, 32'h0);
        @(posedge clk); #1;
        check("base wrap index 3f", bd_read(3, 14'h3F), 32'hCAFEF00D);
        ra[3] = {14'h3FC0, 14'h3FC0};
        wd[3] = {32'h0, 32'h99999999};
        be[3] = {4'h0, 4'hF};
        rv[3] = 2'b11;
        sb[6].push_back(32'h55667788);
        sb[7].push_back(32'h55667788);
        @(posedge clk); #1;
        rv[3] = 2'b00;
        check("base same-cycle write", bd_read(3, 14'h0), 32'h99999999);
        @(posedge clk); #1;

        issue(4, 0, 14'h20, 32'h0BADF00D, 4'hF, 32'h0);
        check("l4 in wait valid", 32'(sv[4][0]), 32'h0);
        check("l4 in wait ready", 32'(rr[4][0]), 32'h0);
        #2 rst_n = 0;
        #1;
        check("async rst valid", 32'(sv[4]), 32'h0);
        check("async rst ready", 32'(rr[4]), 32'h0);
        check("async rst data", rd[4][31:0], 32'h0);
        sb[8].delete();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check("ready after mid rst", 32'(rr[4][0]), 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("no rsp after rst %0d", i), 32'(sv[4][0]), 32'h0);
        end
        check("write kept after rst", bd_read(4, 14'h20), 32'h0BADF00D);
        check("array kept after rst", bd_read(0, 14'd5), 32'hDEADBEEF);

        for (int k = 0; k < ND * 2; k++)
            check($sformatf("pending rsp q%0d", k), 32'(sb[k].size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
